// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 frame sequencer: FSM encoding,
// receiver address width and default frame geometry.
package ov7670_pkg;

    localparam int ADDR_W       = 10;
    localparam int H_WIDTH_DEF  = 320;
    localparam int V_WIDTH_DEF  = 240;
    localparam int FRAME_PIXELS = H_WIDTH_DEF * V_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        SWAP_WAIT,
        NEXT
    } state_t;

    function automatic int pixel_total(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/ov7670_frame_ctrl_if.sv
// Control, receiver and frame-buffer signals of the frame sequencer.
// The master side drives the stimulus; the slave side is the sequencer.
interface ov7670_frame_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                            enable;
    logic                            single;
    logic                            rcv_valid;
    logic [ov7670_pkg::ADDR_W-1:0]   rcv_h_addr;
    logic [ov7670_pkg::ADDR_W-1:0]   rcv_v_addr;
    logic                            vga_vblank;
    logic                            start_capture;
    logic                            next_frame;
    logic                            wr_en;
    logic                            wr_buf;
    logic                            rd_buf;
    logic                            frame_done;
    logic [CNT_WIDTH-1:0]            frame_cnt;
    logic                            frame_err;
    logic                            timeout;
    logic                            busy;

    modport master (
        output enable, single, rcv_valid, rcv_h_addr, rcv_v_addr, vga_vblank,
        input  start_capture, next_frame, wr_en, wr_buf, rd_buf, frame_done,
               frame_cnt, frame_err, timeout, busy
    );

    modport slave (
        input  enable, single, rcv_valid, rcv_h_addr, rcv_v_addr, vga_vblank,
        output start_capture, next_frame, wr_en, wr_buf, rd_buf, frame_done,
               frame_cnt, frame_err, timeout, busy
    );

endinterface

// File: rtl/ov7670_stall_timer.sv
// Counts consecutive enabled cycles without a receiver strobe and flags
// the cycle on which the count reaches TIMEOUT_CYC.
module ov7670_stall_timer #(
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_reg;

    // expire marks the TIMEOUT_CYC-th quiet cycle; the count holds there
    assign expire = enable && !clear && (cnt_reg == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!enable || clear) begin
            cnt_reg <= '0;
        end else if (!expire) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// Frame-level sequencer: arms the receiver, gates pixel writes into one
// ping-pong half, verifies frame size and swaps halves on VGA vblank.
module ov7670_frame_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_WIDTH     = 320,
    parameter int V_WIDTH     = 240,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    ov7670_frame_ctrl_if.slave  bus
);
    localparam int                FRAME_PIX = pixel_total(H_WIDTH, V_WIDTH);
    localparam int                PIX_W     = $clog2(FRAME_PIX + 2);
    localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(FRAME_PIX);
    localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(FRAME_PIX + 1);
    localparam logic [ADDR_W-1:0] H_LAST    = ADDR_W'(H_WIDTH - 1);
    localparam logic [ADDR_W-1:0] V_LAST    = ADDR_W'(V_WIDTH - 1);

    state_t               state_reg, state_next;
    logic                 single_reg, single_next;
    logic                 wr_buf_reg, wr_buf_next;
    logic                 rd_buf_reg, rd_buf_next;
    logic [PIX_W-1:0]     pix_cnt_reg, pix_cnt_next;
    logic [CNT_WIDTH-1:0] frame_cnt_reg, frame_cnt_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 timeout_reg, timeout_next;
    logic                 start_capture_reg, start_capture_next;
    logic                 next_frame_reg, next_frame_next;
    logic                 frame_done_reg, frame_done_next;

    logic                 origin_hit;
    logic                 last_hit;
    logic                 timer_en;
    logic                 stall_expire;
    logic [PIX_W-1:0]     pix_inc;

    assign origin_hit = bus.rcv_valid && (bus.rcv_h_addr == '0) && (bus.rcv_v_addr == '0);
    assign last_hit   = bus.rcv_valid && (bus.rcv_h_addr == H_LAST) && (bus.rcv_v_addr == V_LAST);
    assign pix_inc    = (pix_cnt_reg == PIX_SAT) ? PIX_SAT : pix_cnt_reg + 1'b1;
    assign timer_en   = (state_reg == ARM) || (state_reg == CAPTURE);

    ov7670_stall_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (timer_en),
        .clear  (bus.rcv_valid),
        .expire (stall_expire)
    );

    always_comb begin
        state_next         = state_reg;
        single_next        = single_reg;
        wr_buf_next        = wr_buf_reg;
        rd_buf_next        = rd_buf_reg;
        pix_cnt_next       = pix_cnt_reg;
        frame_cnt_next     = frame_cnt_reg;
        frame_err_next     = frame_err_reg;
        timeout_next       = timeout_reg;
        start_capture_next = 1'b0;
        next_frame_next    = 1'b0;
        frame_done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.enable || bus.single) begin
                    state_next         = ARM;
                    start_capture_next = 1'b1;
                    single_next        = bus.single;
                    frame_err_next     = 1'b0;
                    timeout_next       = 1'b0;
                end
            end
            ARM: begin
                if (origin_hit) begin
                    pix_cnt_next = PIX_W'(1);
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.rcv_valid) begin
                    pix_cnt_next = pix_inc;
                    if (last_hit) begin
                        if (pix_inc == PIX_FULL) begin
                            state_next = SWAP_WAIT;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = NEXT;
                        end
                    end
                end
            end
            SWAP_WAIT: begin
                if (bus.vga_vblank) begin
                    wr_buf_next     = rd_buf_reg;
                    rd_buf_next     = wr_buf_reg;
                    frame_done_next = 1'b1;
                    frame_cnt_next  = frame_cnt_reg + 1'b1;
                    state_next      = NEXT;
                end
            end
            NEXT: begin
                next_frame_next = 1'b1;
                state_next      = (single_reg || !bus.enable) ? IDLE : ARM;
            end
            default: state_next = IDLE;
        endcase

        // Stall only fires in ARM/CAPTURE with no strobe, so nothing above was taken
        if (stall_expire) begin
            state_next      = IDLE;
            timeout_next    = 1'b1;
            next_frame_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            single_reg        <= 1'b0;
            wr_buf_reg        <= 1'b0;
            rd_buf_reg        <= 1'b1;
            pix_cnt_reg       <= '0;
            frame_cnt_reg     <= '0;
            frame_err_reg     <= 1'b0;
            timeout_reg       <= 1'b0;
            start_capture_reg <= 1'b0;
            next_frame_reg    <= 1'b0;
            frame_done_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            single_reg        <= single_next;
            wr_buf_reg        <= wr_buf_next;
            rd_buf_reg        <= rd_buf_next;
            pix_cnt_reg       <= pix_cnt_next;
            frame_cnt_reg     <= frame_cnt_next;
            frame_err_reg     <= frame_err_next;
            timeout_reg       <= timeout_next;
            start_capture_reg <= start_capture_next;
            next_frame_reg    <= next_frame_next;
            frame_done_reg    <= frame_done_next;
        end
    end

    assign bus.wr_en         = bus.rcv_valid && ((state_reg == CAPTURE) || ((state_reg == ARM) && origin_hit));
    assign bus.wr_buf        = wr_buf_reg;
    assign bus.rd_buf        = rd_buf_reg;
    assign bus.start_capture = start_capture_reg;
    assign bus.next_frame    = next_frame_reg;
    assign bus.frame_done    = frame_done_reg;
    assign bus.frame_cnt     = frame_cnt_reg;
    assign bus.frame_err     = frame_err_reg;
    assign bus.timeout       = timeout_reg;
    assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Self-checking bench for ov7670_frame_ctrl on a reduced 8x4 frame with a
// 1000-cycle stall limit; published frames are scored against a queue.
module tb_ov7670_frame_ctrl;
    import ov7670_pkg::*;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int TO   = 1000;
    localparam int CW   = 16;
    localparam int NPIX = H * V;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          rd;
    } exp_t;

    typedef struct {
        int skip_row;
        bit vb_last;
        int drop_at;
        bit exp_pub;
        bit exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ov7670_frame_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    ov7670_frame_ctrl #(
        .H_WIDTH     (H),
        .V_WIDTH     (V),
        .TIMEOUT_CYC (TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_start  = 0;
    int   n_next   = 0;
    int   n_done   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vblank();
        bus.vga_vblank = 1'b1;
        tick();
        bus.vga_vblank = 1'b0;
    endtask

    // Drives a raster frame; skip_row omits one line, stop_at truncates the frame
    task automatic drive_frame(input int skip_row, input bit vb_last, input int drop_at,
                               input int stop_at, output int wr_seen);
        int k;
        k       = 0;
        wr_seen = 0;
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                if (v == skip_row) continue;
                if (k == stop_at) begin
                    bus.rcv_valid  = 1'b0;
                    bus.vga_vblank = 1'b0;
                    return;
                end
                if (k == drop_at) bus.enable = 1'b0;
                bus.rcv_valid  = 1'b1;
                bus.rcv_h_addr = 10'(h);
                bus.rcv_v_addr = 10'(v);
                bus.vga_vblank = vb_last && (v == V - 1) && (h == H - 1);
                #1;
                if (bus.wr_en) wr_seen++;
                tick();
                k++;
            end
        end
        bus.rcv_valid  = 1'b0;
        bus.vga_vblank = 1'b0;
    endtask

    // Pulse counters and the publish scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.start_capture) n_start++;
        if (bus.next_frame) n_next++;
        if (bus.frame_done) begin
            n_done++;
            check("done_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("done_frame_cnt", 32'(bus.frame_cnt), 32'(mon_e.cnt));
                check("done_rd_buf", 32'(bus.rd_buf), 32'(mon_e.rd));
                check("done_wr_buf", 32'(bus.wr_buf), 32'(!mon_e.rd));
                $display("publish: frame_cnt=%0d rd_buf=%0d wr_buf=%0d", bus.frame_cnt, bus.rd_buf, bus.wr_buf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   wr;
        int   pub_cnt;
        bit   exp_rd;
        bit   err_seen;
        int   done_before;
        int   next_before;
        int   waited;

        vecs[0] = '{skip_row: -1, vb_last: 1'b0, drop_at: -1,       exp_pub: 1'b1, exp_busy: 1'b1};
        vecs[1] = '{skip_row:  1, vb_last: 1'b0, drop_at: -1,       exp_pub: 1'b0, exp_busy: 1'b1};
        vecs[2] = '{skip_row: -1, vb_last: 1'b1, drop_at: -1,       exp_pub: 1'b1, exp_busy: 1'b1};
        vecs[3] = '{skip_row: -1, vb_last: 1'b0, drop_at: NPIX / 2, exp_pub: 1'b1, exp_busy: 1'b0};

        pub_cnt  = 0;
        exp_rd   = 1'b1;
        err_seen = 1'b0;

        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.single     = 1'b0;
        bus.rcv_valid  = 1'b0;
        bus.rcv_h_addr = '0;
        bus.rcv_v_addr = '0;
        bus.vga_vblank = 1'b0;
        repeat (3) tick();

        check("reset_busy", 32'(bus.busy), 0);
        check("reset_rd_buf", 32'(bus.rd_buf), 1);
        check("reset_wr_buf", 32'(bus.wr_buf), 0);
        check("reset_frame_cnt", 32'(bus.frame_cnt), 0);
        check("reset_frame_err", 32'(bus.frame_err), 0);
        check("reset_timeout", 32'(bus.timeout), 0);
        rst = 1'b0;
        tick();
        check("idle_no_start", 32'(n_start), 0);

        // Continuous capture through the vector table
        bus.enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            done_before = n_done;
            drive_frame(vecs[i].skip_row, vecs[i].vb_last, vecs[i].drop_at, NPIX + 1, wr);
            check("wr_en_count", 32'(wr), 32'((vecs[i].skip_row >= 0) ? NPIX - H : NPIX));
            if (!vecs[i].exp_pub) err_seen = 1'b1;
            repeat (3) tick();
            check("frame_err", 32'(bus.frame_err), 32'(err_seen));
            check("no_swap_before_vblank", 32'(n_done), 32'(done_before));
            check("rd_buf_hold", 32'(bus.rd_buf), 32'(exp_rd));
            if (vecs[i].exp_pub) begin
                pub_cnt++;
                exp_rd = !exp_rd;
                exp_q.push_back('{cnt: CW'(pub_cnt), rd: exp_rd});
            end
            pulse_vblank();
            repeat (3) tick();
            check("frame_published", 32'(n_done), 32'(done_before + (vecs[i].exp_pub ? 1 : 0)));
            check("busy_after_frame", 32'(bus.busy), 32'(vecs[i].exp_busy));
            $display("vector %0d: wr=%0d done=%0d err=%0d rd_buf=%0d busy=%0d",
                     i, wr, n_done - done_before, bus.frame_err, bus.rd_buf, bus.busy);
        end
        check("start_capture_once", 32'(n_start), 1);

        // Single-shot frame with enable low; a stray pixel in ARM is dropped
        done_before = n_done;
        next_before = n_next;
        bus.single  = 1'b1;
        tick();
        bus.single  = 1'b0;
        check("single_busy", 32'(bus.busy), 1);
        check("single_err_cleared", 32'(bus.frame_err), 0);
        bus.rcv_valid  = 1'b1;
        bus.rcv_h_addr = 10'd3;
        bus.rcv_v_addr = 10'd2;
        #1;
        check("arm_drop_wr_en", 32'(bus.wr_en), 0);
        tick();
        bus.rcv_valid = 1'b0;
        drive_frame(-1, 1'b0, -1, NPIX + 1, wr);
        check("single_wr_count", 32'(wr), NPIX);
        pub_cnt++;
        exp_rd = !exp_rd;
        exp_q.push_back('{cnt: CW'(pub_cnt), rd: exp_rd});
        tick();
        pulse_vblank();
        repeat (4) tick();
        check("single_done", 32'(n_done), 32'(done_before + 1));
        check("single_next_frame", 32'(n_next), 32'(next_before + 1));
        check("single_idle", 32'(bus.busy), 0);
        check("single_start", 32'(n_start), 2);
        $display("single: done=%0d next=%0d busy=%0d", n_done - done_before, n_next - next_before, bus.busy);

        // Stall mid-frame until the timeout fires
        bus.enable = 1'b1;
        tick();
        tick();
        bus.enable  = 1'b0;
        done_before = n_done;
        next_before = n_next;
        drive_frame(-1, 1'b0, -1, NPIX / 2, wr);
        waited = 0;
        while (!bus.timeout && waited < TO + 50) begin
            tick();
            waited++;
        end
        check("timeout_latency", 32'(waited), TO);
        check("timeout_idle", 32'(bus.busy), 0);
        tick();
        check("timeout_next_frame", 32'(n_next), 32'(next_before + 1));
        check("timeout_no_swap", 32'(n_done), 32'(done_before));
        check("timeout_rd_buf", 32'(bus.rd_buf), 32'(exp_rd));
        repeat (5) tick();
        check("timeout_sticky", 32'(bus.timeout), 1);
        bus.enable = 1'b1;
        tick();
        tick();
        check("timeout_cleared", 32'(bus.timeout), 0);
        $display("timeout: latency=%0d busy_after_rearm=%0d", waited, bus.busy);

        // Publish one more frame, then reset in the middle of the next
        drive_frame(-1, 1'b0, -1, NPIX + 1, wr);
        pub_cnt++;
        exp_rd = !exp_rd;
        exp_q.push_back('{cnt: CW'(pub_cnt), rd: exp_rd});
        tick();
        pulse_vblank();
        repeat (3) tick();
        check("pre_reset_rd_buf", 32'(bus.rd_buf), 0);
        drive_frame(-1, 1'b0, -1, NPIX / 2, wr);
        bus.enable     = 1'b0;
        bus.rcv_valid  = 1'b1;
        bus.rcv_h_addr = 10'd5;
        bus.rcv_v_addr = 10'd2;
        rst            = 1'b1;
        #1;
        check("midreset_busy", 32'(bus.busy), 0);
        check("midreset_rd_buf", 32'(bus.rd_buf), 1);
        check("midreset_wr_buf", 32'(bus.wr_buf), 0);
        check("midreset_frame_cnt", 32'(bus.frame_cnt), 0);
        check("midreset_wr_en", 32'(bus.wr_en), 0);
        check("midreset_pulses", 32'({bus.start_capture, bus.next_frame, bus.frame_done}), 0);
        $display("mid-frame reset: rd_buf=%0d wr_buf=%0d frame_cnt=%0d", bus.rd_buf, bus.wr_buf, bus.frame_cnt);
        bus.rcv_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
